// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared word width, fetch FSM encodings and default reset vector
package instruction_fetch_pkg;
   localparam int WORD_WIDTH = 16;
   typedef logic [WORD_WIDTH-1:0] word_t;
   localparam logic [0:0] FETCH_RUN    = 1'b0;
   localparam logic [0:0] FETCH_HALTED = 1'b1;
   localparam word_t DEFAULT_RESET_VECTOR = 16'h0000;
endpackage

// File: rtl/instruction_fetch_skid_buffer.sv
// instruction_fetch_skid_buffer: one-entry hold register plus output mux between memory read data and decode
module instruction_fetch_skid_buffer
   import instruction_fetch_pkg::*;
(
   input  logic  clock,
   input  logic  reset_n,
   input  logic  i_flush,
   input  logic  i_in_valid,
   input  word_t i_in_data,
   input  word_t i_in_tag,
   input  logic  i_ready,
   output logic  o_valid,
   output word_t o_data,
   output word_t o_tag
);
   logic  r_hold_valid;
   word_t r_hold_data;
   word_t r_hold_tag;
   // Capture the memory word when decode stalls so later memory writes cannot disturb it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
         r_hold_tag   <= '0;
      end else if (i_flush) begin
         r_hold_valid <= 1'b0;
      end else if (r_hold_valid) begin
         if (i_ready) r_hold_valid <= 1'b0;
      end else if (i_in_valid && !i_ready) begin
         r_hold_valid <= 1'b1;
         r_hold_data  <= i_in_data;
         r_hold_tag   <= i_in_tag;
      end
   end
   // Held entry wins over the live memory word; nothing pending drives zeros
   always_comb begin
      o_valid = r_hold_valid | i_in_valid;
      o_data  = r_hold_valid ? r_hold_data : i_in_valid ? i_in_data : '0;
      o_tag   = r_hold_valid ? r_hold_tag  : i_in_valid ? i_in_tag  : '0;
   end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter owner that streams memory words to decode over valid/ready
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter word_t RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic  clock,
   input  logic  reset_n,
   output word_t program_counter,
   input  word_t current_instruction,
   output word_t instruction,
   output word_t instruction_pc,
   output logic  instruction_valid,
   input  logic  instruction_ready,
   input  logic  jump_enable,
   input  word_t jump_target,
   input  logic  halt,
   input  logic  resume
);
   word_t      r_pc;
   logic       r_inflight;
   word_t      r_inflight_pc;
   logic [0:0] r_state;
   logic       w_stall;
   logic       w_issue;
   // A fetch goes out only while running, decode is not blocked and no redirect/halt arrives
   always_comb begin
      w_stall = instruction_valid & ~instruction_ready;
      w_issue = (r_state == FETCH_RUN) & ~w_stall & ~jump_enable & ~halt;
   end
   // PC, in-flight tracking and run/halt state; halt beats resume when both pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc          <= RESET_VECTOR;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_state       <= FETCH_RUN;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) r_inflight_pc <= r_pc;
         r_pc    <= jump_enable ? jump_target : w_issue ? r_pc + 16'd1 : r_pc;
         r_state <= halt ? FETCH_HALTED : resume ? FETCH_RUN : r_state;
      end
   end
   assign program_counter = r_pc;
   instruction_fetch_skid_buffer u_skid (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_flush    (jump_enable),
      .i_in_valid (r_inflight),
      .i_in_data  (current_instruction),
      .i_in_tag   (r_inflight_pc),
      .i_ready    (instruction_ready),
      .o_valid    (instruction_valid),
      .o_data     (instruction),
      .o_tag      (instruction_pc)
   );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized stream checked against an in-order fetch model
module tb_instruction_fetch;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ready = 1'b1;
   logic        jump = 1'b0;
   logic [15:0] target = '0;
   logic        halt = 1'b0;
   logic        resume = 1'b0;
   logic [15:0] pc_a, rd_a, instr_a, ipc_a;
   logic [15:0] pc_b, rd_b, instr_b, ipc_b;
   logic        valid_a, valid_b;
   logic [15:0] mem [0:65535];
   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      rd_a <= mem[pc_a];
      rd_b <= mem[pc_b];
   end

   instruction_fetch dut_a (
      .clock(clock), .reset_n(reset_n), .program_counter(pc_a), .current_instruction(rd_a),
      .instruction(instr_a), .instruction_pc(ipc_a), .instruction_valid(valid_a),
      .instruction_ready(ready), .jump_enable(jump), .jump_target(target),
      .halt(halt), .resume(resume)
   );

   instruction_fetch #(.RESET_VECTOR(16'hFFFE)) dut_b (
      .clock(clock), .reset_n(reset_n), .program_counter(pc_b), .current_instruction(rd_b),
      .instruction(instr_b), .instruction_pc(ipc_b), .instruction_valid(valid_b),
      .instruction_ready(ready), .jump_enable(jump), .jump_target(target),
      .halt(halt), .resume(resume)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset_n = 1'b0; ready = 1'b1; jump = 1'b0; halt = 1'b0; resume = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 16'hA000 + 16'(i);
      tick;
      tick;
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      tick;
      total++; if (pc_a !== 16'h0000) begin bad++; $display("FAIL reset_pc got %h expected 0000", pc_a); end
      total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got %b expected 0", valid_a); end
      total++; if (instr_a !== 16'h0000) begin bad++; $display("FAIL reset_instr got %h expected 0000", instr_a); end
      total++; if (ipc_a !== 16'h0000) begin bad++; $display("FAIL reset_ipc got %h expected 0000", ipc_a); end
      total++; if (pc_b !== 16'hFFFE) begin bad++; $display("FAIL reset_vector_pc got %h expected fffe", pc_b); end
   endtask

   task automatic test_stream_stall;
      do_reset;
      total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL stream_first_valid got %b expected 0", valid_a); end
      for (int i = 0; i < 2; i++) begin
         tick;
         total++; if (!valid_a || ipc_a !== 16'(i) || instr_a !== 16'hA000 + 16'(i)) begin
            bad++; $display("FAIL stream_%0d got v=%b pc=%h i=%h expected pc=%h", i, valid_a, ipc_a, instr_a, 16'(i));
         end
      end
      ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         if (k == 0) mem[1] = 16'hFFFF;
         total++; if (!valid_a || ipc_a !== 16'h0001 || instr_a !== 16'hA001 || pc_a !== 16'h0002) begin
            bad++; $display("FAIL stall_hold_%0d got v=%b pc=%h i=%h fpc=%h expected pc=0001 i=a001 fpc=0002", k, valid_a, ipc_a, instr_a, pc_a);
         end
      end
      ready = 1'b1;
      tick;
      total++; if (!valid_a || ipc_a !== 16'h0002 || instr_a !== 16'hA002) begin
         bad++; $display("FAIL stall_recover got v=%b pc=%h i=%h expected pc=0002 i=a002", valid_a, ipc_a, instr_a);
      end
      tick;
      total++; if (!valid_a || ipc_a !== 16'h0003) begin
         bad++; $display("FAIL stall_next got v=%b pc=%h expected pc=0003", valid_a, ipc_a);
      end
   endtask

   task automatic test_jump;
      do_reset;
      for (int i = 0; i < 6; i++) tick;
      total++; if (!valid_a || ipc_a !== 16'h0005) begin bad++; $display("FAIL jump_pre got v=%b pc=%h expected pc=0005", valid_a, ipc_a); end
      jump = 1'b1; target = 16'h0040;
      tick;
      jump = 1'b0;
      total++; if (valid_a !== 1'b0 || pc_a !== 16'h0040) begin
         bad++; $display("FAIL jump_bubble got v=%b fpc=%h expected v=0 fpc=0040", valid_a, pc_a);
      end
      tick;
      total++; if (!valid_a || ipc_a !== 16'h0040 || instr_a !== mem[16'h0040]) begin
         bad++; $display("FAIL jump_target got v=%b pc=%h i=%h expected pc=0040 i=%h", valid_a, ipc_a, instr_a, mem[16'h0040]);
      end
      tick;
      total++; if (!valid_a || ipc_a !== 16'h0041) begin bad++; $display("FAIL jump_follow got v=%b pc=%h expected pc=0041", valid_a, ipc_a); end
   endtask

   task automatic test_wrap;
      logic [15:0] e;
      do_reset;
      e = 16'hFFFE;
      for (int i = 0; i < 4; i++) begin
         tick;
         total++; if (!valid_b || ipc_b !== e || instr_b !== mem[e]) begin
            bad++; $display("FAIL wrap_%0d got v=%b pc=%h i=%h expected pc=%h i=%h", i, valid_b, ipc_b, instr_b, e, mem[e]);
         end
         e = e + 16'd1;
      end
   endtask

   task automatic test_halt;
      do_reset;
      for (int i = 0; i < 3; i++) tick;
      total++; if (!valid_a || ipc_a !== 16'h0002) begin bad++; $display("FAIL halt_pre got v=%b pc=%h expected pc=0002", valid_a, ipc_a); end
      halt = 1'b1;
      tick;
      halt = 1'b0;
      for (int k = 0; k < 2; k++) begin
         total++; if (valid_a !== 1'b0 || pc_a !== 16'h0003) begin
            bad++; $display("FAIL halt_frozen_%0d got v=%b fpc=%h expected v=0 fpc=0003", k, valid_a, pc_a);
         end
         tick;
      end
      resume = 1'b1;
      tick;
      resume = 1'b0;
      total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL resume_gap got v=%b expected 0", valid_a); end
      tick;
      total++; if (!valid_a || ipc_a !== 16'h0003 || instr_a !== 16'hA003) begin
         bad++; $display("FAIL resume_fetch got v=%b pc=%h i=%h expected pc=0003 i=a003", valid_a, ipc_a, instr_a);
      end
   endtask

   task automatic test_async_reset;
      do_reset;
      tick;
      tick;
      ready = 1'b0;
      tick;
      tick;
      total++; if (!valid_a || ipc_a !== 16'h0001) begin bad++; $display("FAIL areset_pre got v=%b pc=%h expected pc=0001", valid_a, ipc_a); end
      #2;
      reset_n = 1'b0;
      #1;
      total++; if (valid_a !== 1'b0 || instr_a !== 16'h0000 || ipc_a !== 16'h0000 || pc_a !== 16'h0000) begin
         bad++; $display("FAIL areset_now got v=%b i=%h pc=%h fpc=%h expected all zero", valid_a, instr_a, ipc_a, pc_a);
      end
      tick;
      reset_n = 1'b1;
      ready = 1'b1;
      tick;
      total++; if (!valid_a || ipc_a !== 16'h0000 || instr_a !== 16'hA000) begin
         bad++; $display("FAIL areset_restart got v=%b pc=%h i=%h expected pc=0000 i=a000", valid_a, ipc_a, instr_a);
      end
   endtask

   task automatic test_random;
      logic [15:0] exp_pc;
      logic        run_m, go, acc;
      int          accepts;
      do_reset;
      exp_pc = 16'h0000; run_m = 1'b1; go = 1'b0; accepts = 0;
      for (int n = 0; n < 3000; n++) begin
         if (valid_a) begin
            total++; if (ipc_a !== exp_pc || instr_a !== mem[exp_pc]) begin
               bad++; $display("FAIL rand_order cyc=%0d got pc=%h i=%h expected pc=%h i=%h", n, ipc_a, instr_a, exp_pc, mem[exp_pc]);
            end
         end
         if (go) begin
            total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL rand_bubble cyc=%0d got v=%b expected 1", n, valid_a); end
         end
         ready  = ($urandom_range(3) != 0);
         jump   = ($urandom_range(15) == 0);
         target = 16'($urandom);
         halt   = ($urandom_range(31) == 0);
         resume = ($urandom_range(7) == 0);
         acc = valid_a & ready;
         if (acc) begin exp_pc = exp_pc + 16'd1; accepts++; end
         if (jump) exp_pc = target;
         go = acc & run_m & ~jump & ~halt;
         run_m = halt ? 1'b0 : resume ? 1'b1 : run_m;
         tick;
      end
      ready = 1'b1; jump = 1'b0; halt = 1'b0; resume = 1'b0;
      total++; if (accepts < 500) begin bad++; $display("FAIL rand_progress got %0d accepts expected at least 500", accepts); end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
      test_reset;
      test_stream_stall;
      test_jump;
      test_wrap;
      test_halt;
      test_async_reset;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
